// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional round-robin arbitration is selected with MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  localparam int DW = 16;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select between the fetch and data requesters.
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: data always wins ties.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic any_req,
  output logic owner
);

  always_comb begin
    any_req = if_req | d_req;
    owner   = OWN_IF;
    if (d_req && !if_req) begin
      owner = OWN_D;
    end else if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      // On a tie the requester that was not served last goes first.
      owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
`else
      owner = OWN_D;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  input  logic          hlt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output state_e        fsm_state
);

  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  // Handshake: a requester holds req and its payload until it sees a one-cycle
  // gnt; the accepted transaction then answers with a one-cycle valid.
  state_e          state;
  state_e          state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      cnt_nxt;
  logic            take;
  logic            last_done;
  logic            pick_any;
  logic            pick_owner;

  logic            owner;
  logic            lat_wr;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            if_gnt_q;
  logic            d_gnt_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

`ifdef MEM_ARB_RR_EN
  logic            last_owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_IF;
    end else if (take) begin
      last_owner <= pick_owner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .any_req    (pick_any),
    .owner      (pick_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    last_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!hlt && pick_any) begin
          take      = 1'b1;
          cnt_nxt   = LAT_M1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == 3'd0) begin
          last_done = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Fetches never write, so their wr and wdata are latched as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IF;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_gnt_q <= take && (pick_owner == OWN_IF);
      d_gnt_q  <= take && (pick_owner == OWN_D);
      if (take) begin
        owner     <= pick_owner;
        lat_wr    <= (pick_owner == OWN_D) && d_wr;
        lat_addr  <= (pick_owner == OWN_D) ? d_addr : if_addr;
        lat_wdata <= (pick_owner == OWN_D) ? d_wdata : '0;
      end
      if (last_done) begin
        if (owner == OWN_D) begin
          d_rdata_q <= lat_wr ? '0 : mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state == ST_ACCESS);
  assign mem_wr    = mem_en && lat_wr;
  assign mem_addr  = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = (state == ST_RESP) && (owner == OWN_IF);
  assign d_valid   = (state == ST_RESP) && (owner == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, randomized run
// against a cycle-arithmetic model, reset/halt sequences and latency sweeps.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int L = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        hlt;
  logic [15:0] mem_xor;
  logic [15:0] mem_rdata;

  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_wr, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  state_e      fsm_state;

  logic [1:0]  ax_if_gnt, ax_if_valid, ax_d_gnt, ax_d_valid, ax_mem_en, ax_mem_wr, ax_busy;
  logic [15:0] ax_if_rdata [2];
  logic [15:0] ax_d_rdata [2];
  logic [15:0] ax_mem_addr [2];
  logic [15:0] ax_mem_wdata [2];
  state_e      ax_state [2];

  int          n_vec;
  int          n_err;
  logic [16:0] exp_q [$];

  logic [6:0]  ob;
  logic [70:0] out_all;

  assign mem_rdata = mem_addr ^ mem_xor;
  assign ob        = {if_gnt, d_gnt, mem_en, mem_wr, if_valid, d_valid, busy};
  assign out_all   = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                      mem_en, mem_wr, mem_addr, mem_wdata, busy};

  mem_arbiter #(.LATENCY(L), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .hlt(hlt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  mem_arbiter #(.LATENCY(1), .AW(16)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(1'b1), .if_addr(16'h0100), .if_gnt(ax_if_gnt[0]), .if_valid(ax_if_valid[0]),
    .if_rdata(ax_if_rdata[0]),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_gnt(ax_d_gnt[0]), .d_valid(ax_d_valid[0]), .d_rdata(ax_d_rdata[0]),
    .hlt(1'b0), .mem_en(ax_mem_en[0]), .mem_wr(ax_mem_wr[0]), .mem_addr(ax_mem_addr[0]),
    .mem_wdata(ax_mem_wdata[0]), .mem_rdata(16'h0000), .busy(ax_busy[0]), .fsm_state(ax_state[0])
  );

  mem_arbiter #(.LATENCY(7), .AW(16)) dut_l7 (
    .clk(clk), .rst(rst),
    .if_req(1'b1), .if_addr(16'h0200), .if_gnt(ax_if_gnt[1]), .if_valid(ax_if_valid[1]),
    .if_rdata(ax_if_rdata[1]),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_gnt(ax_d_gnt[1]), .d_valid(ax_d_valid[1]), .d_rdata(ax_d_rdata[1]),
    .hlt(1'b0), .mem_en(ax_mem_en[1]), .mem_wr(ax_mem_wr[1]), .mem_addr(ax_mem_addr[1]),
    .mem_wdata(ax_mem_wdata[1]), .mem_rdata(16'h0000), .busy(ax_busy[1]), .fsm_state(ax_state[1])
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]  in;    // {if_req, d_req, d_wr, hlt}
    logic [6:0]  out;   // {if_gnt, d_gnt, mem_en, mem_wr, if_valid, d_valid, busy}
    logic [15:0] maddr;
    logic [15:0] ird;
    logic [15:0] drd;
  } vec_t;

  function automatic vec_t mk(logic [3:0] in, logic [6:0] out, logic [15:0] maddr,
                              logic [15:0] ird, logic [15:0] drd);
    vec_t v;
    v.in = in; v.out = out; v.maddr = maddr; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  function automatic logic aux_valid(int k);
    return (k == 1) ? ax_if_valid[0] : ax_if_valid[1];
  endfunction

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; hlt = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
  endtask

  task automatic run_table();
    vec_t tbl [$];
    logic [15:0] x;
    logic [15:0] y;
    x = 16'hA5A5;
    y = 16'hA5F5;
    if_addr = 16'h0010; d_addr = 16'h0040; d_wdata = 16'h1234;
    tbl.push_back(mk(4'b1000, 7'b0000000, 16'h0000, 16'h0000, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b1010001, 16'h0010, 16'h0000, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0010001, 16'h0010, 16'h0000, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0000101, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0000000, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0110, 7'b0000000, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0111001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0011001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0000011, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0000000, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b1100, 7'b0000000, 16'h0000, x, 16'h0));
`ifdef MEM_ARB_RR_EN
    tbl.push_back(mk(4'b0100, 7'b1010001, 16'h0010, x, 16'h0));
    tbl.push_back(mk(4'b0100, 7'b0010001, 16'h0010, x, 16'h0));
    tbl.push_back(mk(4'b0100, 7'b0000101, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0100, 7'b0000000, 16'h0000, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0110001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0010001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b0000, 7'b0000011, 16'h0000, x, y));
    tbl.push_back(mk(4'b0000, 7'b0000000, 16'h0000, x, y));
`else
    tbl.push_back(mk(4'b1000, 7'b0110001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b1000, 7'b0010001, 16'h0040, x, 16'h0));
    tbl.push_back(mk(4'b1000, 7'b0000011, 16'h0000, x, y));
    tbl.push_back(mk(4'b1000, 7'b0000000, 16'h0000, x, y));
    tbl.push_back(mk(4'b0000, 7'b1010001, 16'h0010, x, y));
    tbl.push_back(mk(4'b0000, 7'b0010001, 16'h0010, x, y));
    tbl.push_back(mk(4'b0000, 7'b0000101, 16'h0000, x, y));
    tbl.push_back(mk(4'b0000, 7'b0000000, 16'h0000, x, y));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      {if_req, d_req, d_wr, hlt} = tbl[i].in;
      check($sformatf("vec%0d_ctl", i), 80'(ob), 80'(tbl[i].out));
      if (tbl[i].out[4]) check($sformatf("vec%0d_addr", i), 80'(mem_addr), 80'(tbl[i].maddr));
      if (tbl[i].out[3]) check($sformatf("vec%0d_wdata", i), 80'(mem_wdata), 80'h1234);
      check($sformatf("vec%0d_rdata", i), 80'({if_rdata, d_rdata}), 80'({tbl[i].ird, tbl[i].drd}));
      tick();
    end
  endtask

  // Reference model: a grant at edge c occupies the memory for cycles
  // c..c+L-1, answers in cycle c+L and frees the arbiter from cycle c+L+1.
  task automatic run_random(int n);
    int          g_cyc;
    int          m_free;
    logic        g_own;
    logic        g_wr;
    logic        m_last;
    logic        men;
    logic [15:0] g_addr;
    logic [15:0] g_wdata;
    logic [15:0] e_ird;
    logic [15:0] e_drd;
    logic [6:0]  e_ob;
    logic [16:0] got;
    logic [16:0] exp;
    g_cyc = -100; m_free = 0; g_own = OWN_IF; g_wr = 1'b0; m_last = OWN_D;
    g_addr = 16'h0; g_wdata = 16'h0; e_ird = 16'hA5A5; e_drd = 16'hA5F5;
    for (int c = 1; c <= n + L + 4; c++) begin
      @(posedge clk);
      if ((c - 1) >= m_free && !hlt && (if_req || d_req)) begin
        g_own = d_req ? OWN_D : OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) g_own = (m_last == OWN_D) ? OWN_IF : OWN_D;
`endif
        m_last  = g_own;
        g_cyc   = c;
        m_free  = c + L + 1;
        g_wr    = (g_own == OWN_D) && d_wr;
        g_addr  = (g_own == OWN_D) ? d_addr : if_addr;
        g_wdata = d_wdata;
        exp_q.push_back({g_own, g_wr ? 16'h0000 : (g_addr ^ mem_xor)});
      end
      #1;
      men  = (c >= g_cyc) && (c < g_cyc + L);
      e_ob = {(c == g_cyc) && (g_own == OWN_IF), (c == g_cyc) && (g_own == OWN_D),
              men, men && g_wr,
              (c == g_cyc + L) && (g_own == OWN_IF), (c == g_cyc + L) && (g_own == OWN_D),
              (c >= g_cyc) && (c <= g_cyc + L)};
      check($sformatf("rand%0d_ctl", c), 80'(ob), 80'(e_ob));
      if (men) check($sformatf("rand%0d_addr", c), 80'(mem_addr), 80'(g_addr));
      if (men && g_wr) check($sformatf("rand%0d_wdata", c), 80'(mem_wdata), 80'(g_wdata));
      if (if_valid || d_valid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand%0d_sb_empty", c), 80'(1), 80'(0));
        end else begin
          exp = exp_q.pop_front();
          got = {d_valid, d_valid ? d_rdata : if_rdata};
          check($sformatf("rand%0d_scoreboard", c), 80'(got), 80'(exp));
          if (exp[16]) e_drd = exp[15:0];
          else         e_ird = exp[15:0];
        end
      end
      check($sformatf("rand%0d_rdata_hold", c), 80'({if_rdata, d_rdata}), 80'({e_ird, e_drd}));
      if (c >= n) begin
        if_req = 1'b0; d_req = 1'b0; hlt = 1'b0;
      end else begin
        if (if_gnt || !if_req) begin
          if_req  = ($urandom_range(0, 2) != 0);
          if_addr = 16'($urandom);
        end
        if (d_gnt || !d_req) begin
          d_req   = ($urandom_range(0, 2) != 0);
          d_wr    = 1'($urandom_range(0, 1));
          d_addr  = 16'($urandom);
          d_wdata = 16'($urandom);
        end
        hlt = ($urandom_range(0, 7) == 0);
      end
    end
    check("rand_sb_drain", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic run_halt();
    drive_idle();
    if_addr = 16'h0010;
    if_req  = 1'b1;
    tick();
    check("hlt_gnt", 80'(if_gnt), 80'(1));
    hlt = 1'b1;
    tick();
    tick();
    check("hlt_inflight_valid", 80'({if_valid, if_rdata}), 80'({1'b1, 16'hA5A5}));
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hlt_block%0d", i), 80'({if_gnt, d_gnt, busy}), 80'(0));
    end
    hlt = 1'b0;
    tick();
    check("hlt_release_gnt", 80'(if_gnt), 80'(1));
    if_req = 1'b0;
    tick();
    tick();
    check("hlt_release_valid", 80'(if_valid), 80'(1));
    tick();
  endtask

  task automatic run_reset_abort();
    drive_idle();
    d_addr = 16'h0080;
    d_req  = 1'b1;
    tick();
    check("rst_pre_gnt", 80'(d_gnt), 80'(1));
    tick();
    check("rst_access2", 80'(mem_en), 80'(1));
    rst = 1'b0;
    #1;
    check("rst_async_outputs", 80'(out_all), 80'(0));
    check("rst_async_state", 80'(fsm_state), 80'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold%0d", i), 80'(out_all), 80'(0));
    end
    rst = 1'b1;
    tick();
    check("rst_fresh_gnt", 80'({d_gnt, mem_en}), 80'(2'b11));
    d_req = 1'b0;
    tick();
    tick();
    check("rst_fresh_valid", 80'({d_valid, d_rdata}), 80'({1'b1, 16'h0080 ^ 16'hA5B5}));
    tick();
  endtask

  task automatic measure_period(int k);
    logic found;
    int   gap;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (aux_valid(k)) found = 1'b1;
    end
    check($sformatf("lat%0d_first_valid", k), 80'(found), 80'(1));
    for (int g = 0; g < 3; g++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!aux_valid(k) && gap < 40);
      check($sformatf("lat%0d_period%0d", k, g), 80'(gap), 80'(k + 2));
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    mem_xor = 16'hA5B5;
    drive_idle();
    tick();
    tick();
    check("reset_outputs", 80'(out_all), 80'(0));
    check("reset_state", 80'(fsm_state), 80'(ST_IDLE));
    rst = 1'b1;
    run_table();
    run_random(400);
    run_halt();
    run_reset_abort();
    measure_period(1);
    measure_period(7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: memory access cycles per transaction, legal 1..7.
REQ-002 Parameter AW, default 16: address width; data width fixed at 16.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 if_valid  output  1  one-cycle pulse: if_rdata valid.
REQ-009 if_rdata  output  16  fetched instruction word.
REQ-010 d_req  input  1  data request; held with d_wr/d_addr/d_wdata until d_gnt.
REQ-011 d_wr  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  16  store data.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 d_valid  output  1  one-cycle pulse: load data valid or store complete.
REQ-016 d_rdata  output  16  load data; 0 on store completion.
REQ-017 hlt  input  1  when 1, no new grants; in-flight transaction completes.
REQ-018 mem_en, mem_wr  output  1 each  memory enable / write strobe.
REQ-019 mem_addr  output  AW; mem_wdata  output  16  memory address and write data.
REQ-020 mem_rdata  input  16  memory read data, valid in the last ACCESS cycle.
REQ-021 busy  output  1  1 in any state other than IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; single transaction outstanding.
REQ-023 IDLE: at a clock edge with hlt=0 and any req=1, latch winner's address, wr and wdata plus owner id, load counter with LATENCY-1, go to ACCESS; else stay.
REQ-024 Winner's gnt is a registered pulse in the first ACCESS cycle; loser's req stays pending, not dropped.
REQ-025 ACCESS: mem_en=1, mem_addr/mem_wdata/mem_wr from latched values, stable for all LATENCY cycles; counter decrements; at counter==0 go to RESP.
REQ-026 At the ACCESS-to-RESP edge, a load captures mem_rdata into owner's rdata register; a store sets it to 0.
REQ-027 RESP: owner's valid=1 for exactly one cycle, mem_en=0; next state IDLE.
REQ-028 Fetch requests are never stores: mem_wr=0 for fetch transactions.
REQ-029 Per-transaction latency req-sample to valid = LATENCY+1 cycles; back-to-back period = LATENCY+2 cycles.
REQ-030 Default arbitration fixed: d_req wins over if_req when both are 1.
REQ-031 hlt rising during ACCESS/RESP does not abort; FSM returns to IDLE and waits.
REQ-032 rdata outputs hold their last captured value outside valid cycles.

Reset
REQ-033 rst=0 forces IDLE immediately, discards any in-flight transaction; all outputs 0, rdata registers 0, counter 0, last-winner flag = fetch.
REQ-034 No valid or gnt pulse is produced for a transaction aborted by reset.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not served last wins; the last-winner flag updates on every grant.
REQ-036 MEM_ARB_RR_EN undefined: fixed data priority per REQ-030; no last-winner flag logic.

Structure
REQ-037 Shared package holds FSM state enum (IDLE/ACCESS/RESP), owner id constants (OWN_IF=0, OWN_D=1), data width constant 16.
REQ-038 One sub-module natural: mem_arb_pick (combinational winner select, contains MEM_ARB_RR_EN logic).

Verification
REQ-039 LATENCY=2, if_req, if_addr=0x0010, mem returns 0xA5A5 -> if_gnt at cycle 1, mem_en cycles 1-2, if_valid at cycle 3 with if_rdata=0xA5A5.
REQ-040 d_req store d_addr=0x0040 d_wdata=0x1234 -> mem_wr=1, mem_addr=0x0040, mem_wdata=0x1234 for 2 cycles; d_valid=1, d_rdata=0.
REQ-041 if_req and d_req same cycle, fixed mode -> data served first, fetch granted 4 cycles later; RR mode with last winner=data -> fetch first.
REQ-042 rst=0 in second ACCESS cycle -> all outputs 0 immediately, no valid pulse; after release with requests held, fresh grant issued.
REQ-043 hlt=1 in ACCESS with if_req pending -> in-flight completes with valid; no grant until hlt=0, then grant next cycle.
REQ-044 LATENCY=1 and LATENCY=7, continuous if_req -> valid every 3 / 9 cycles respectively.
